// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue, stall, flush and retire sequencing for the LAT-stage EX multiplier.
// Define MUL_ISSUE_CTRL_PERF_EN to add the perf_issued/perf_stall counters and the perf_clr input.
module mul_issue_ctrl #(
  parameter int LAT   = 2,
  parameter int TAG_W = 5
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  output logic             mul_signed,
  output logic             mul_adv,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
`ifdef MUL_ISSUE_CTRL_PERF_EN
  input  logic             perf_clr,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
`endif
  output logic             busy
);

  localparam int         LAST     = LAT - 1;
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b10;

  logic [LAT-1:0]   vld_reg;
  logic [1:0]       op_reg   [LAT];
  logic [TAG_W-1:0] tag_reg  [LAT];

  logic [LAT-1:0]   vld_next;
  logic [1:0]       op_next  [LAT];
  logic [TAG_W-1:0] tag_next [LAT];

  logic       stall;
  logic       fire_in;
  logic [1:0] op_norm;

  assign stall    = vld_reg[LAST] & ~out_ready;
  assign mul_adv  = ~stall | flush;
  assign in_ready = ~stall & ~flush;
  assign fire_in  = in_valid & in_ready;

  assign mul_x      = in_x;
  assign mul_y      = in_y;
  assign mul_signed = (in_op != OP_MULHU);
  // The reserved encoding behaves as MUL.W, so it selects the low half at retirement.
  assign op_norm    = (in_op == 2'b11) ? OP_MUL : in_op;

  // Stage 0 loads the request (or a bubble); every later stage takes its predecessor.
  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign vld_next[gi] = fire_in;
        assign op_next[gi]  = op_norm;
        assign tag_next[gi] = in_tag;
      end else begin : g_body
        assign vld_next[gi] = vld_reg[gi-1];
        assign op_next[gi]  = op_reg[gi-1];
        assign tag_next[gi] = tag_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      vld_reg <= '0;
      for (int k = 0; k < LAT; k++) begin
        op_reg[k]  <= OP_MUL;
        tag_reg[k] <= '0;
      end
    end else if (flush) begin
      vld_reg <= '0;
    end else if (mul_adv) begin
      vld_reg <= vld_next;
      for (int k = 0; k < LAT; k++) begin
        op_reg[k]  <= op_next[k];
        tag_reg[k] <= tag_next[k];
      end
    end
  end

  // A flush cycle never retires: the consumer must not see the doomed head op.
  assign out_valid = vld_reg[LAST] & ~flush;
  assign out_tag   = tag_reg[LAST];
  assign out_data  = (op_reg[LAST] == OP_MUL) ? mul_result[31:0] : mul_result[63:32];
  assign busy      = |vld_reg;

`ifdef MUL_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge mul_clk) begin
    if (reset || perf_clr) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (fire_in && (perf_issued_reg != 32'hFFFF_FFFF)) begin
        perf_issued_reg <= perf_issued_reg + 32'd1;
      end
      if (stall && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl at LAT=2 with a 2-stage multiplier model gated by mul_adv.
// Perf counter checks run only when MUL_ISSUE_CTRL_PERF_EN is defined.
module tb_mul_issue_ctrl;
  localparam int LAT   = 2;
  localparam int TAG_W = 5;

  logic             mul_clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_x = '0;
  logic [31:0]      in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic             mul_signed;
  logic             mul_adv;
  logic [63:0]      mul_result;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef MUL_ISSUE_CTRL_PERF_EN
  logic             perf_clr = 1'b0;
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  mul_issue_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_tag     (in_tag),
    .flush      (flush),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_adv    (mul_adv),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
`ifdef MUL_ISSUE_CTRL_PERF_EN
    .perf_clr   (perf_clr),
    .perf_issued(perf_issued),
    .perf_stall (perf_stall),
`endif
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  // Stand-in for the Booth/Wallace datapath: two register stages frozen by mul_adv.
  logic [63:0] prod;
  logic [63:0] m0 = '0;
  logic [63:0] m1 = '0;
  always_comb begin
    prod = '0;
    if (mul_signed) prod = {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
    else            prod = {32'b0, mul_x} * {32'b0, mul_y};
  end
  always @(posedge mul_clk) begin
    if (mul_adv) begin
      m0 <= prod;
      m1 <= m0;
    end
  end
  assign mul_result = m1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_op    = op;
    in_x     = x;
    in_y     = y;
    in_tag   = tag;
  endtask

  task automatic run_single(input string name, input logic [1:0] op,
                            input logic [31:0] exp_data, input logic exp_signed);
    drive(1'b1, op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    #1;
    chk({name, "_in_ready"}, in_ready, 1'b1);
    chk({name, "_signed"}, mul_signed, exp_signed);
    chk({name, "_mul_x"}, mul_x, 32'hFFFF_FFFF);
    cyc();
    drive(1'b0, 2'b00, '0, '0, '0);
    #1;
    chk({name, "_early_valid"}, out_valid, 1'b0);
    chk({name, "_busy"}, busy, 1'b1);
    cyc();
    #1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_data"}, out_data, exp_data);
    chk({name, "_tag"}, out_tag, 5'd3);
    $display("txn %s tag=%0d data=0x%08h", name, out_tag, out_data);
    cyc();
    #1;
    chk({name, "_drained"}, busy, 1'b0);
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mul_adv", mul_adv, 1'b1);

    // Single ops, each tagged 3
    run_single("mulw", 2'b00, 32'h0000_0001, 1'b1);
    run_single("mulhw", 2'b01, 32'h0000_0000, 1'b1);
    run_single("mulhwu", 2'b10, 32'hFFFF_FFFE, 1'b0);
    run_single("rsvd", 2'b11, 32'h0000_0001, 1'b1);

    // Back-to-back MULH.W, tags 0..3
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, TAG_W'(i));
      else       drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      if (i < 4) chk($sformatf("b2b_in_ready%0d", i), in_ready, 1'b1);
      if (i >= 2) begin
        chk($sformatf("b2b_valid%0d", i - 2), out_valid, 1'b1);
        chk($sformatf("b2b_data%0d", i - 2), out_data, 32'h4000_0000);
        chk($sformatf("b2b_tag%0d", i - 2), out_tag, TAG_W'(i - 2));
        $display("txn b2b tag=%0d data=0x%08h", out_tag, out_data);
      end
      cyc();
    end
    #1;
    chk("b2b_drained", busy, 1'b0);

    // Backpressure: out_ready low across 5 stalled cycles with 3 ops pending
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd5);
    cyc();
    drive(1'b1, 2'b00, 32'd4, 32'd5, 5'd6);
    #1;
    chk("bp_in_ready_p1", in_ready, 1'b1);
    cyc();
    drive(1'b1, 2'b00, 32'd10, 32'd10, 5'd7);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_in_ready_s%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_mul_adv_s%0d", i), mul_adv, 1'b0);
      chk($sformatf("bp_valid_s%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_data_s%0d", i), out_data, 32'd6);
      chk($sformatf("bp_tag_s%0d", i), out_tag, 5'd5);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_out0_data", out_data, 32'd6);
    chk("bp_out0_tag", out_tag, 5'd5);
    $display("txn bp tag=%0d data=0x%08h", out_tag, out_data);
    cyc();
    drive(1'b0, 2'b00, '0, '0, '0);
    #1;
    chk("bp_out1_valid", out_valid, 1'b1);
    chk("bp_out1_data", out_data, 32'd20);
    chk("bp_out1_tag", out_tag, 5'd6);
    $display("txn bp tag=%0d data=0x%08h", out_tag, out_data);
    cyc();
    #1;
    chk("bp_out2_valid", out_valid, 1'b1);
    chk("bp_out2_data", out_data, 32'd100);
    chk("bp_out2_tag", out_tag, 5'd7);
    $display("txn bp tag=%0d data=0x%08h", out_tag, out_data);
    cyc();
    #1;
    chk("bp_drained_valid", out_valid, 1'b0);
    chk("bp_drained_busy", busy, 1'b0);

    // Flush one cycle after two issues
    drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd1);
    cyc();
    drive(1'b1, 2'b00, 32'd3, 32'd4, 5'd2);
    cyc();
    flush = 1'b1;
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd9);
    #1;
    chk("fl_in_ready", in_ready, 1'b0);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_mul_adv", mul_adv, 1'b1);
    cyc();
    flush = 1'b0;
    drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd4);
    #1;
    chk("fl_busy_after", busy, 1'b0);
    chk("fl_in_ready_after", in_ready, 1'b1);
    chk("fl_out_valid_after", out_valid, 1'b0);
    cyc();
    drive(1'b0, 2'b00, '0, '0, '0);
    #1;
    chk("fl_no_stale", out_valid, 1'b0);
    cyc();
    #1;
    chk("fl_fresh_valid", out_valid, 1'b1);
    chk("fl_fresh_data", out_data, 32'h0000_002A);
    chk("fl_fresh_tag", out_tag, 5'd4);
    $display("txn flush_fresh tag=%0d data=0x%08h", out_tag, out_data);
    cyc();

    // Reset with the pipeline full and stalled
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd1);
    cyc();
    drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd2);
    cyc();
    drive(1'b0, 2'b00, '0, '0, '0);
    #1;
    chk("rm_stalled", in_ready, 1'b0);
    chk("rm_full", busy, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    #1;
    chk("rm_out_valid", out_valid, 1'b0);
    chk("rm_busy", busy, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rm_in_ready", in_ready, 1'b1);

`ifdef MUL_ISSUE_CTRL_PERF_EN
    chk("perf_rst_issued", perf_issued, 32'd0);
    chk("perf_rst_stall", perf_stall, 32'd0);
    cyc();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b00, 32'(i), 32'd1, TAG_W'(i));
      cyc();
    end
    drive(1'b0, 2'b00, '0, '0, '0);
    cyc();
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd10);
    cyc();
    drive(1'b0, 2'b00, '0, '0, '0);
    cyc();
    for (int i = 0; i < 4; i++) cyc();
    out_ready = 1'b1;
    cyc();
    #1;
    chk("perf_issued", perf_issued, 32'd10);
    chk("perf_stall", perf_stall, 32'd4);
    $display("txn perf issued=%0d stall=%0d", perf_issued, perf_stall);
    perf_clr = 1'b1;
    drive(1'b1, 2'b00, 32'd1, 32'd1, 5'd1);
    cyc();
    perf_clr = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    #1;
    chk("perf_clr_issued", perf_issued, 32'd0);
    chk("perf_clr_stall", perf_stall, 32'd0);
    cyc();
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
